// File: rtl/lfsr16_checker.sv
// Self-synchronising checker for the 16-bit XNOR PRBS (taps 15,14,12,3): hunt, verify, flywheel-locked check.
// Optional sticky error/loss flags are built when LFSR_CHK_STICKY_EN is defined.
module lfsr16_checker #(
    parameter int LOCK_MATCHES = 32,
    parameter int LOSS_ERRORS  = 4,
    parameter int LOSS_WINDOW  = 64,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_cnt,
`ifdef LFSR_CHK_STICKY_EN
    input  logic             sticky_clr,
    output logic             err_sticky,
    output logic             lost_sticky,
`endif
    output logic             locked,
    output logic             bit_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam int MATCH_W = $clog2(LOCK_MATCHES + 1);
    localparam int WIN_W   = $clog2(LOSS_WINDOW);
    localparam int WERR_W  = $clog2(LOSS_ERRORS + 1);

    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_MATCHES - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(LOSS_WINDOW - 1);
    localparam logic [WERR_W-1:0]  ERR_LIMIT  = WERR_W'(LOSS_ERRORS);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [15:0]        sr_q, sr_d;
    logic [3:0]         fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0]  win_err_q, win_err_d;
    logic [CNT_W-1:0]   err_cnt_d, bit_cnt_d;
    logic               bit_err_d;
    logic               lost;
    logic               pred;

    assign pred = ~(sr_q[15] ^ sr_q[14] ^ sr_q[12] ^ sr_q[3]);

    always_comb begin
        // NOTE: every target gets a hold/default value first so no path can infer a latch.
        state_d   = state_q;
        sr_d      = sr_q;
        fill_d    = fill_q;
        match_d   = match_q;
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        err_cnt_d = err_cnt;
        bit_cnt_d = bit_cnt;
        bit_err_d = 1'b0;
        lost      = 1'b0;

        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    sr_d   = {sr_q[14:0], in_bit};
                    fill_d = fill_q + 1'b1;
                    if (fill_q == 4'd15) begin
                        state_d = VERIFY;
                        match_d = '0;
                    end
                end
                VERIFY: begin
                    sr_d = {sr_q[14:0], in_bit};
                    // All-ones is the XNOR lock-up state: it predicts itself forever, so never trust it.
                    if (in_bit == pred && sr_q != 16'hFFFF) begin
                        match_d = match_q + 1'b1;
                        if (match_q == MATCH_LAST) begin
                            state_d   = LOCKED;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    sr_d      = {sr_q[14:0], pred};
                    win_cnt_d = win_cnt_q + 1'b1;
                    if (bit_cnt != '1) bit_cnt_d = bit_cnt + 1'b1;
                    if (in_bit != pred) begin
                        bit_err_d = 1'b1;
                        win_err_d = win_err_q + 1'b1;
                        if (err_cnt != '1) err_cnt_d = err_cnt + 1'b1;
                    end
                    if (win_err_d == ERR_LIMIT) begin
                        state_d = HUNT;
                        fill_d  = '0;
                        lost    = 1'b1;
                    end else if (win_cnt_q == WIN_LAST) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (clr_cnt) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= HUNT;
            sr_q      <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            win_cnt_q <= '0;
            win_err_q <= '0;
            locked    <= 1'b0;
            bit_err   <= 1'b0;
            err_cnt   <= '0;
            bit_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
            locked    <= (state_d == LOCKED);
            bit_err   <= bit_err_d;
            err_cnt   <= err_cnt_d;
            bit_cnt   <= bit_cnt_d;
        end
    end

`ifdef LFSR_CHK_STICKY_EN
    // Set has priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_sticky  <= 1'b0;
            lost_sticky <= 1'b0;
        end else begin
            err_sticky  <= bit_err_d | (err_sticky & ~sticky_clr);
            lost_sticky <= lost | (lost_sticky & ~sticky_clr);
        end
    end
`endif

endmodule

// File: tb/tb_lfsr16_checker.sv
// Directed/randomised bench for lfsr16_checker against a queue-based behavioural model.
module tb_lfsr16_checker;

    localparam int LOCK_MATCHES = 32;
    localparam int LOSS_ERRORS  = 4;
    localparam int LOSS_WINDOW  = 64;
    localparam int CNT_W        = 16;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic clr_cnt = 1'b0;
    logic locked, bit_err;
    logic [CNT_W-1:0] err_cnt, bit_cnt;
`ifdef LFSR_CHK_STICKY_EN
    logic sticky_clr = 1'b0;
    logic err_sticky, lost_sticky;
`endif

    lfsr16_checker #(
        .LOCK_MATCHES(LOCK_MATCHES), .LOSS_ERRORS(LOSS_ERRORS),
        .LOSS_WINDOW(LOSS_WINDOW), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
`ifdef LFSR_CHK_STICKY_EN
        .sticky_clr(sticky_clr), .err_sticky(err_sticky), .lost_sticky(lost_sticky),
`endif
        .locked(locked), .bit_err(bit_err), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: mode 0=hunt 1=verify 2=locked; hist holds the last 16 reference bits, oldest first.
    int  mode, nfill, nmatch, nwin, nwerr, m_err, m_bits;
    bit  m_biterr, m_err_st, m_lost_st;
    bit  hist[$];
    logic [15:0] gen_state;

    function automatic bit model_pred();
        return ~(hist[0] ^ hist[1] ^ hist[3] ^ hist[12]);
    endfunction

    function automatic bit model_all_ones();
        foreach (hist[i]) if (hist[i] == 1'b0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        mode = 0; nfill = 0; nmatch = 0; nwin = 0; nwerr = 0;
        m_err = 0; m_bits = 0; m_biterr = 0; m_err_st = 0; m_lost_st = 0;
        hist = {};
        for (int i = 0; i < 16; i++) hist.push_back(1'b0);
    endtask

    task automatic model_step(input bit v, input bit b, input bit c);
        bit p, ok;
        m_biterr = 1'b0;
        if (v) begin
            p = model_pred();
            case (mode)
                0: begin
                    void'(hist.pop_front()); hist.push_back(b);
                    nfill++;
                    if (nfill == 16) begin mode = 1; nfill = 0; nmatch = 0; end
                end
                1: begin
                    ok = (b == p) && !model_all_ones();
                    void'(hist.pop_front()); hist.push_back(b);
                    nmatch = ok ? nmatch + 1 : 0;
                    if (nmatch == LOCK_MATCHES) begin mode = 2; nwin = 0; nwerr = 0; end
                end
                default: begin
                    void'(hist.pop_front()); hist.push_back(p);
                    if (m_bits < CNT_MAX) m_bits++;
                    nwin++;
                    if (b != p) begin
                        m_biterr = 1'b1; m_err_st = 1'b1;
                        nwerr++;
                        if (m_err < CNT_MAX) m_err++;
                    end
                    if (nwerr == LOSS_ERRORS) begin
                        mode = 0; nfill = 0; m_lost_st = 1'b1;
                    end else if (nwin == LOSS_WINDOW) begin
                        nwin = 0; nwerr = 0;
                    end
                end
            endcase
        end
        if (c) begin m_err = 0; m_bits = 0; end
    endtask

    task automatic compare_all();
        check("locked", locked, 32'(mode == 2));
        check("bit_err", bit_err, 32'(m_biterr));
        check("err_cnt", err_cnt, m_err);
        check("bit_cnt", bit_cnt, m_bits);
`ifdef LFSR_CHK_STICKY_EN
        check("err_sticky", err_sticky, 32'(m_err_st));
        check("lost_sticky", lost_sticky, 32'(m_lost_st));
`endif
    endtask

    task automatic cycle(input bit v, input bit b, input bit c);
        in_valid = v; in_bit = b; clr_cnt = c;
        @(posedge clk);
        model_step(v, b, c);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; clr_cnt = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        compare_all();
        reset = 1'b0;
    endtask

    // Generator: next bit is the XNOR of taps, shifted into bit 0.
    task automatic next_gen(output bit b);
        b = ~(gen_state[15] ^ gen_state[14] ^ gen_state[12] ^ gen_state[3]);
        gen_state = {gen_state[14:0], b};
    endtask

    task automatic send(input bit flip, input bit c);
        bit b;
        next_gen(b);
        cycle(1'b1, b ^ flip, c);
    endtask

    initial begin
        int pulses, gaps;
        bit seen_lock;
        model_reset();

        // Power-on reset.
        do_reset();
        do_reset();
        check("reset_locked", locked, 0);
        check("reset_err_cnt", err_cnt, 0);

        // Clean lock from generator state 0.
        gen_state = 16'h0000;
        for (int i = 0; i < 47; i++) send(1'b0, 1'b0);
        check("not_locked_at_47", locked, 0);
        send(1'b0, 1'b0);
        check("locked_at_48", locked, 1);
        for (int i = 0; i < 20; i++) send(1'b0, 1'b0);
        check("bit_cnt_after_20", bit_cnt, 20);
        check("err_cnt_clean", err_cnt, 0);

        // Single error, then 100 clean bits.
        send(1'b1, 1'b0);
        check("single_bit_err", bit_err, 1);
        check("single_err_cnt", err_cnt, 1);
        check("single_locked", locked, 1);
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            send(1'b0, 1'b0);
            if (bit_err) pulses++;
        end
        check("no_extra_pulses", pulses, 0);

        // Idle cycles with random bits hold everything.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'($urandom), 1'b0);

        // Three errors per window across three windows.
        cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < LOSS_WINDOW && nwin != 0; i++) send(1'b0, 1'b0);
        for (int w = 0; w < 3; w++)
            for (int i = 0; i < LOSS_WINDOW; i++)
                send(1'(i == 5 || i == 20 || i == 40 + w), 1'b0);
        check("three_per_window_locked", locked, 1);
        check("three_per_window_err_cnt", err_cnt, 9);

        // Four errors inside one window drop lock on the fourth.
        for (int i = 0; i < 7; i++) send(1'(i % 2 == 1), 1'b0);
        check("before_4th_locked", locked, 1);
        send(1'b1, 1'b0);
        check("loss_on_4th", locked, 0);
        check("loss_keeps_err_cnt", err_cnt, 13);

        // Stuck-high line never locks, then the real sequence locks within 48 bits.
        seen_lock = 1'b0;
        for (int i = 0; i < 500; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            if (locked) seen_lock = 1'b1;
        end
        check("stuck_never_locks", seen_lock, 0);
        gen_state = 16'h0000;
        for (int i = 0; i < 48 && !locked; i++) send(1'b0, 1'b0);
        check("relock_after_stuck", locked, 1);

        // Gapped run must match the contiguous result: 48 lock bits, 40 checked, one error.
        do_reset();
        gen_state = 16'h0000;
        for (int i = 0; i < 88; i++) begin
            gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) cycle(1'b0, 1'($urandom), 1'b0);
            send(1'(i == 60), 1'b0);
        end
        check("gapped_locked", locked, 1);
        check("gapped_err_cnt", err_cnt, 1);
        check("gapped_bit_cnt", bit_cnt, 40);

        // Clear coincident with an error.
        send(1'b1, 1'b1);
        check("clr_err_cnt", err_cnt, 0);
        check("clr_bit_cnt", bit_cnt, 0);
        check("clr_locked", locked, 1);

`ifdef LFSR_CHK_STICKY_EN
        sticky_clr = 1'b1;
        @(posedge clk);
        m_err_st = 1'b0; m_lost_st = 1'b0;
        #1;
        compare_all();
        sticky_clr = 1'b0;
`endif

        // Reset while locked, then a full relock.
        do_reset();
        check("reset_locked_out", locked, 0);
        check("reset_bit_cnt_out", bit_cnt, 0);
        gen_state = 16'h0000;
        for (int i = 0; i < 47; i++) send(1'b0, 1'b0);
        check("relock_not_at_47", locked, 0);
        send(1'b0, 1'b0);
        check("relock_at_48", locked, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
